// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_BITS = 2;
  localparam int WORD_BITS   = 32;
  localparam int LINE_BITS   = BLOCK_WORDS * WORD_BITS;
  localparam int OFFSET_LSB  = 0;
  localparam int INDEX_LSB   = OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_MEM  = 2'd2
  } state_e;

  function automatic logic [WORD_BITS-1:0] pick_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [OFFSET_BITS-1:0] off);
    logic [WORD_BITS-1:0] w;
    case (off)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      2'd3:    w = line[127:96];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: per-line valid/tag/data, asynchronously cleared valid bits,
// one combinational read port, one full-line write port and one word write port.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_BITS-1:0]  rd_index_i,
  output logic                   rd_valid_o,
  output logic [TAG_BITS-1:0]    rd_tag_o,
  output logic [LINE_BITS-1:0]   rd_line_o,
  input  logic                   line_we_i,
  input  logic [INDEX_BITS-1:0]  line_index_i,
  input  logic [TAG_BITS-1:0]    line_tag_i,
  input  logic [LINE_BITS-1:0]   line_data_i,
  input  logic                   word_we_i,
  input  logic [INDEX_BITS-1:0]  word_index_i,
  input  logic [OFFSET_BITS-1:0] word_offset_i,
  input  logic [WORD_BITS-1:0]   word_data_i
);

  localparam int NUM_LINES = 1 << INDEX_BITS;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // Valid bits: cleared by reset, set when a refill lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[line_index_i] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag and data storage; a refill and a store-hit never coincide
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[line_index_i]  <= line_tag_i;
      data_q[line_index_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[word_index_i][{word_offset_i, 5'd0} +: WORD_BITS] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache_wt_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller: FSM and
// main-memory request/ready handshake around dcache_line_array.
module dcache_wt_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [127:0]         mem_block,
  input  logic                 mem_ready
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int TAG_LSB  = INDEX_LSB + INDEX_BITS;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;

  logic [ADDR_BITS-1:0] look_addr_s;
  logic                 rd_valid_s;
  logic [TAG_BITS-1:0]  rd_tag_s;
  logic [LINE_BITS-1:0] rd_line_s;
  logic                 hit_s;
  logic                 line_we_s, word_we_s;
  logic                 stall_s, mem_read_s, mem_write_s;
  logic [31:0]          rdata_s;

  // Lookups use the CPU address while idle and the latched address otherwise
  assign look_addr_s = (state_q == ST_IDLE) ? cpu_addr : addr_q;
  assign hit_s = rd_valid_s && (rd_tag_s == look_addr_s[ADDR_BITS-1:TAG_LSB]);

  dcache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_index_i    (look_addr_s[TAG_LSB-1:INDEX_LSB]),
    .rd_valid_o    (rd_valid_s),
    .rd_tag_o      (rd_tag_s),
    .rd_line_o     (rd_line_s),
    .line_we_i     (line_we_s),
    .line_index_i  (addr_q[TAG_LSB-1:INDEX_LSB]),
    .line_tag_i    (addr_q[ADDR_BITS-1:TAG_LSB]),
    .line_data_i   (mem_block),
    .word_we_i     (word_we_s),
    .word_index_i  (addr_q[TAG_LSB-1:INDEX_LSB]),
    .word_offset_i (addr_q[OFFSET_BITS-1:OFFSET_LSB]),
    .word_data_i   (wdata_q)
  );

  // State and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state, handshake requests and cache write strobes
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    stall_s     = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    rdata_s     = 32'd0;
    line_we_s   = 1'b0;
    word_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_write) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = ST_WR_MEM;
          stall_s = 1'b1;
        end else if (cpu_read) begin
          if (hit_s) begin
            rdata_s = pick_word(rd_line_s, cpu_addr[OFFSET_BITS-1:OFFSET_LSB]);
          end else begin
            addr_d  = cpu_addr;
            state_d = ST_RD_MISS;
            stall_s = 1'b1;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_RD_MISS: begin
        // Request is dropped in the ready cycle so memory does not re-run it
        mem_read_s = !mem_ready;
        if (mem_ready) begin
          line_we_s = 1'b1;
          rdata_s   = pick_word(mem_block, addr_q[OFFSET_BITS-1:OFFSET_LSB]);
          state_d   = ST_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_WR_MEM: begin
        mem_write_s = !mem_ready;
        if (mem_ready) begin
          word_we_s = hit_s;
          state_d   = ST_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // While reset is held the CPU-facing and memory-facing strobes stay quiet
  assign stall     = rst_n & stall_s;
  assign mem_read  = rst_n & mem_read_s;
  assign mem_write = rst_n & mem_write_s;
  assign cpu_rdata = rst_n ? rdata_s : 32'd0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dcache_wt_controller.sv
// Self-checking bench: behavioural word memory with a 4-cycle handshake and an
// abstract valid/tag cache model; directed scenarios followed by random traffic.
module tb_dcache_wt_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_read, cpu_write;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         stall, mem_read, mem_write;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_block;
  logic         mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [1024];
  bit          m_valid   [32];
  int          m_tag     [32];

  always #5 clk = ~clk;

  dcache_wt_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_block (mem_block),
    .mem_ready (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input int a);
    return m_valid[(a / 4) % 32] && (m_tag[(a / 4) % 32] == a / 128);
  endfunction

  function automatic logic [127:0] model_block(input int a);
    int base;
    base = (a / 4) * 4;
    return {mem_model[base + 3], mem_model[base + 2], mem_model[base + 1], mem_model[base]};
  endfunction

  // One CPU access, checked cycle by cycle while the memory model answers
  task automatic access(input bit rd, input bit wr, input int a, input logic [31:0] d);
    bit is_write;
    bit is_hit;
    bit done;
    bit ready_next;
    int req_cycles;
    is_write   = wr;
    is_hit     = model_hit(a);
    done       = 1'b0;
    req_cycles = 0;
    cpu_read   = rd;
    cpu_write  = wr;
    cpu_addr   = 10'(a);
    cpu_wdata  = d;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      ready_next = 1'b0;
      if (!is_write && is_hit) begin
        chk("hit_stall", 32'(stall), 32'd0);
        chk("hit_rdata", cpu_rdata, mem_model[a]);
        chk("hit_noreq", 32'({mem_read, mem_write}), 32'd0);
        done = 1'b1;
      end else if (c == 0) begin
        chk("t0_stall", 32'(stall), 32'd1);
        chk("t0_noreq", 32'({mem_read, mem_write}), 32'd0);
      end else if (!mem_ready) begin
        chk("req_stall", 32'(stall), 32'd1);
        chk("req_lines", 32'({mem_read, mem_write}), is_write ? 32'd1 : 32'd2);
        chk("req_addr", 32'(mem_addr), 32'(a));
        if (is_write) chk("req_wdata", mem_wdata, d);
        req_cycles++;
        if (req_cycles == 4) ready_next = 1'b1;
      end else begin
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_noreq", 32'({mem_read, mem_write}), 32'd0);
        chk("done_cycle", 32'(c), 32'd5);
        if (is_write) begin
          mem_model[a] = d;
        end else begin
          chk("fill_rdata", cpu_rdata, mem_model[a]);
          m_valid[(a / 4) % 32] = 1'b1;
          m_tag[(a / 4) % 32]   = a / 128;
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_ready = ready_next;
      mem_block = ready_next ? model_block(a) : 128'd0;
      if (done) begin
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a, k, g;
    logic [31:0] d;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'd0;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
    rst_n = 1'b0; mem_ready = 1'b0; mem_block = 128'd0;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 10'h005; cpu_wdata = 32'd0;

    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cpu_read = 1'b0;

    access(1'b0, 1'b1, 'h005, 32'hDEADBEEF);
    access(1'b1, 1'b0, 'h005, 32'd0);
    access(1'b1, 1'b0, 'h006, 32'd0);
    access(1'b0, 1'b1, 'h007, 32'h12345678);
    access(1'b1, 1'b0, 'h007, 32'd0);
    access(1'b1, 1'b0, 'h085, 32'd0);
    access(1'b1, 1'b0, 'h005, 32'd0);
    access(1'b1, 1'b1, 'h010, 32'hCAFEF00D);
    access(1'b1, 1'b0, 'h010, 32'd0);

    // Stray ready while idle must not disturb the cached line
    mem_ready = 1'b1; mem_block = {4{32'hBAD0BAD0}};
    @(negedge clk);
    chk("idle_ready_stall", 32'(stall), 32'd0);
    chk("idle_ready_req", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_block = 128'd0;
    access(1'b1, 1'b0, 'h005, 32'd0);

    // Reset in the middle of a load miss
    cpu_read = 1'b1; cpu_addr = 10'h085;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_miss_req", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'({mem_read, mem_write}), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_maddr", 32'(mem_addr), 32'd0);
    cpu_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    access(1'b1, 1'b0, 'h005, 32'd0);
    access(1'b1, 1'b0, 'h085, 32'd0);

    // Random traffic over a few indices and tags to mix hits, misses and evictions
    for (int n = 0; n < 60; n++) begin
      a = int'($urandom_range(0, 3)) * 128 + int'($urandom_range(0, 3)) * 4 + int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 4));
      d = $urandom;
      if (k <= 2) access(1'b1, 1'b0, a, 32'd0);
      else if (k == 3) access(1'b0, 1'b1, a, d);
      else access(1'b1, 1'b1, a, d);
      g = int'($urandom_range(0, 1));
      if (g == 1) begin
        @(negedge clk);
        chk("gap_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
